// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the sysbus memory sequencer.
// RR_ARB_EN (when defined) selects round-robin arbitration in bus_arb2.
package mem_bus_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} seq_state_t;

  localparam int PORT_CPU  = 0;
  localparam int PORT_HOST = 1;

  // ROM occupies addresses 0..rom_top-1; everything above is RAM.
  function automatic logic is_rom(input logic [31:0] addr, input int unsigned rom_top);
    return addr < rom_top;
  endfunction

endpackage

// File: rtl/bus_arb2.sv
// Two-port bus arbiter: fixed CPU priority by default, round-robin when RR_ARB_EN is defined.
module bus_arb2
  import mem_bus_pkg::*;
(
`ifdef RR_ARB_EN
  input  logic       clock,
  input  logic       reset,
  input  logic       complete,
  input  logic       owner,
`endif
  input  logic [1:0] req,
  output logic [1:0] pick
);

`ifdef RR_ARB_EN
  logic ptr;

  // After a grant finishes, the other port becomes preferred.
  always_ff @(posedge clock) begin
    if (reset) ptr <= 1'b0;
    else if (complete) ptr <= ~owner;
  end

  always_comb begin
    // NOTE: default first so every path assigns pick and no latch is inferred.
    pick = 2'b00;
    if (req[ptr]) pick = ptr ? 2'b10 : 2'b01;
    else if (|req) pick = ptr ? 2'b01 : 2'b10;
  end
`else
  always_comb begin
    pick = 2'b00;
    if (req[PORT_CPU]) pick[PORT_CPU] = 1'b1;
    else if (req[PORT_HOST]) pick[PORT_HOST] = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_bus_sequencer.sv
// Sequences sysbus memory accesses (ROM low, RAM high) for the CPU and host ports.
// Arbitration is fixed priority unless RR_ARB_EN is defined.
module mem_bus_sequencer
  import mem_bus_pkg::*;
#(
  parameter int WORD_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int ROM_TOP     = 20,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              err,
  output logic [WORD_W-1:0] rdata,
  input  logic [WORD_W-1:0] sysbus_in,
  output logic [WORD_W-1:0] sysbus_out,
  output logic              sysbus_oe,
  output logic              load_MAR,
  output logic              MDR_bus,
  output logic              load_MDR,
  output logic              CS_rom,
  output logic              CS_ram,
  output logic              R_NW
);

  localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

  seq_state_t        state;
  logic [1:0]        pick;
  logic              win;
  logic              we_q;
  logic              rom_q;
  logic [WORD_W-1:0] wdata_q;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_rom;

  bus_arb2 u_arb (
`ifdef RR_ARB_EN
    .clock    (clock),
    .reset    (reset),
    .complete (state == DONE),
    .owner    (gnt[PORT_HOST]),
`endif
    .req      (req),
    .pick     (pick)
  );

  assign win      = pick[PORT_HOST];
  assign sel_addr = win ? addr1 : addr0;
  assign sel_rom  = is_rom(32'(sel_addr), ROM_TOP);

  // Outputs are registered: each transition loads the strobes for the state being entered.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      done       <= 2'b00;
      err        <= 1'b0;
      sysbus_oe  <= 1'b0;
      sysbus_out <= '0;
      load_MAR   <= 1'b0;
      MDR_bus    <= 1'b0;
      load_MDR   <= 1'b0;
      CS_rom     <= 1'b0;
      CS_ram     <= 1'b0;
      R_NW       <= 1'b1;
      rdata      <= '0;
      we_q       <= 1'b0;
      rom_q      <= 1'b0;
      wdata_q    <= '0;
      cnt        <= 3'd0;
    end else begin
      done     <= 2'b00;
      err      <= 1'b0;
      load_MAR <= 1'b0;
      load_MDR <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt        <= pick;
            we_q       <= we[win];
            rom_q      <= sel_rom;
            wdata_q    <= win ? wdata1 : wdata0;
            sysbus_oe  <= 1'b1;
            sysbus_out <= WORD_W'(sel_addr);
            load_MAR   <= 1'b1;
            CS_rom     <= sel_rom;
            CS_ram     <= ~sel_rom;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (we_q && rom_q) begin
            // Rejected ROM write: no data phase, straight to completion.
            sysbus_oe <= 1'b0;
            CS_rom    <= 1'b0;
            CS_ram    <= 1'b0;
            done      <= gnt;
            err       <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= 3'd0;
            if (we_q) begin
              sysbus_oe  <= 1'b1;
              sysbus_out <= wdata_q;
              R_NW       <= 1'b0;
              load_MDR   <= (LAST == 3'd0);
            end else begin
              sysbus_oe <= 1'b0;
              MDR_bus   <= 1'b1;
              R_NW      <= 1'b1;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == LAST) begin
            if (!we_q) rdata <= sysbus_in;
            sysbus_oe <= 1'b0;
            MDR_bus   <= 1'b0;
            R_NW      <= 1'b1;
            CS_rom    <= 1'b0;
            CS_ram    <= 1'b0;
            done      <= gnt;
            state     <= DONE;
          end else begin
            cnt      <= cnt + 3'd1;
            load_MDR <= we_q && ((cnt + 3'd1) == LAST);
          end
        end
        DONE: begin
          gnt   <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
